// File: rtl/demux1to3_router.sv
// 1-to-3 valid/ready demultiplexer with a one-entry buffer per channel; S=11 words are dropped and flagged on err.
// Optional drop counter on err_cnt is enabled by defining DEMUX_ERRCNT_EN.
module demux1to3_router #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       S,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic [W-1:0]     out_data0,
  output logic [W-1:0]     out_data1,
  output logic [W-1:0]     out_data2,
  output logic             err
`ifdef DEMUX_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  logic [2:0]   vld_p1;
  logic [W-1:0] data_p1 [3];
  logic         err_p1;

  logic [2:0]   sel_oh;
  logic         illegal;
  logic [2:0]   load;
  logic [2:0]   pop;
  logic         drop;

  // Ready depends only on the addressed buffer, so illegal selects always drain.
  always_comb begin
    sel_oh   = 3'b000;
    in_ready = 1'b1;
    illegal  = 1'b0;
    case (S)
      2'd0: begin
        sel_oh   = 3'b001;
        in_ready = !vld_p1[0] || out_ready[0];
      end
      2'd1: begin
        sel_oh   = 3'b010;
        in_ready = !vld_p1[1] || out_ready[1];
      end
      2'd2: begin
        sel_oh   = 3'b100;
        in_ready = !vld_p1[2] || out_ready[2];
      end
      default: illegal = 1'b1;
    endcase
  end

  assign load = (in_valid && in_ready) ? sel_oh : 3'b000;
  assign pop  = vld_p1 & out_ready;
  assign drop = in_valid && illegal;

  // Stage p1: per-channel buffers and the drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 3'b000;
      err_p1 <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        data_p1[k] <= '0;
      end
    end else begin
      err_p1 <= drop;
      for (int k = 0; k < 3; k++) begin
        if (load[k]) begin
          vld_p1[k]  <= 1'b1;
          data_p1[k] <= in_data;
        end else if (pop[k]) begin
          vld_p1[k]  <= 1'b0;
        end
      end
    end
  end

`ifdef DEMUX_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (drop && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

  assign out_valid = vld_p1;
  assign out_data0 = data_p1[0];
  assign out_data1 = data_p1[1];
  assign out_data2 = data_p1[2];
  assign err       = err_p1;

endmodule
